// File: rtl/queue_pop_reader.sv
// Consumer for the 4-bit x 8 queue. It pops one entry per timed tick in run mode, or one per step edge
// in single-step mode. It latches each popped nibble for the display and counts the pops.
module queue_pop_reader #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             clear,
  input  logic             q_empty,
  input  logic [3:0]       q_data,
  output logic             q_enable,
  output logic             q_push_pop,
  output logic [3:0]       data_hold,
  output logic             valid,
  output logic [CNT_W-1:0] pop_count,
  output logic             busy
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] RELOAD = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_POP,
    S_SETTLE
  } state_t;

  state_t             r_state;
  logic [TW-1:0]      r_tick;
  logic               r_step_d;
  logic [3:0]         r_data_hold;
  logic               r_valid;
  logic [CNT_W-1:0]   r_pop_count;
  logic               w_step_rise;

  assign w_step_rise = step & ~r_step_d;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= step;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state <= S_WAIT;
            r_tick  <= RELOAD;
          end else if (w_step_rise && !q_empty) begin
            r_state <= S_POP;
          end
        end
        S_WAIT: begin
          if (!run) begin
            r_state <= S_IDLE;
          end else if (r_tick != '0) begin
            r_tick <= r_tick - 1'b1;
          end else if (!q_empty) begin
            r_state <= S_POP;
          end else begin
            // Queue was empty on the tick: retry one full period later.
            r_tick <= RELOAD;
          end
        end
        S_POP: r_state <= S_SETTLE;
        S_SETTLE: begin
          if (run) begin
            r_state <= S_WAIT;
            r_tick  <= RELOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Clear takes priority over a same-cycle capture; the queue still sees its pop.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_data_hold <= 4'h0;
      r_valid     <= 1'b0;
      r_pop_count <= '0;
    end else if (r_state == S_POP) begin
      r_data_hold <= q_data;
      r_valid     <= 1'b1;
      r_pop_count <= r_pop_count + 1'b1;
    end
  end

  assign q_enable   = (r_state == S_POP);
  assign q_push_pop = 1'b0;
  assign busy       = (r_state != S_IDLE);
  assign data_hold  = r_data_hold;
  assign valid      = r_valid;
  assign pop_count  = r_pop_count;

endmodule

// File: tb/tb_queue_pop_reader.sv
// Bench for queue_pop_reader. A small queue model feeds the DUT, and a timeline model predicts the
// outputs on every cycle. Directed scenarios cover the corner cases.
module tb_queue_pop_reader;

  localparam int TD = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          clear = 1'b0;
  logic          q_empty = 1'b1;
  logic [3:0]    q_data = 4'h0;
  logic          q_enable;
  logic          q_push_pop;
  logic [3:0]    data_hold;
  logic          valid;
  logic [CW-1:0] pop_count;
  logic          busy;

  always #5 clk = ~clk;

  queue_pop_reader #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .clear      (clear),
    .q_empty    (q_empty),
    .q_data     (q_data),
    .q_enable   (q_enable),
    .q_push_pop (q_push_pop),
    .data_hold  (data_hold),
    .valid      (valid),
    .pop_count  (pop_count),
    .busy       (busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  // Queue environment: the head and empty flag change only on the falling edge.
  // A pop seen there takes effect on the next falling edge, so the DUT captures the old head.
  logic [3:0] fifo[$];

  always @(negedge clk) begin
    q_empty = (fifo.size() == 0);
    q_data  = q_empty ? 4'h0 : fifo[0];
    if (q_enable && !q_push_pop && fifo.size() > 0) void'(fifo.pop_front());
  end

  // The reference model is a single timeline position:
  //   -1 means idle.
  //   0..TD-1 means cycles spent waiting for the tick.
  //   TD means the pop cycle.
  //   TD+1 means the settle cycle.
  int         m_phase = -1;
  bit         m_step_d = 1'b0;
  bit         m_valid = 1'b0;
  logic [3:0] m_hold = 4'h0;
  int         m_count = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = -1; m_step_d = 1'b0; m_valid = 1'b0; m_hold = 4'h0; m_count = 0;
    end else begin
      if (clear) begin
        m_hold = 4'h0; m_valid = 1'b0; m_count = 0;
      end else if (m_phase == TD) begin
        m_hold = q_data; m_valid = 1'b1; m_count = (m_count + 1) % (1 << CW);
      end
      if (m_phase == -1) begin
        if (run) m_phase = 0;
        else if (step && !m_step_d && !q_empty) m_phase = TD;
      end else if (m_phase < TD) begin
        if (!run) m_phase = -1;
        else if (m_phase < TD - 1) m_phase = m_phase + 1;
        else m_phase = q_empty ? 0 : TD;
      end else if (m_phase == TD) begin
        m_phase = TD + 1;
      end else begin
        m_phase = run ? 0 : -1;
      end
      m_step_d = step;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (q_enable) pulses++;
    if (chk_en) begin
      check("model_q_enable", q_enable, int'(m_phase == TD));
      check("model_busy", busy, int'(m_phase != -1));
      check("model_data_hold", data_hold, m_hold);
      check("model_valid", valid, m_valid);
      check("model_pop_count", pop_count, m_count);
      check("q_push_pop", q_push_pop, 0);
    end
  endtask

  typedef struct {
    bit run;
    bit step;
    bit clear;
    bit en;
    bit bsy;
  } vec_t;

  vec_t       vecs[12];
  int         c0, p0, sz, n, k, guard;
  bit         prev_en, chk255;
  int         offs[$];
  logic [3:0] caps[$];

  initial begin
    // Single-step table. The queue holds 5 and 9, and step is held high for ten cycles.
    vecs[0] = '{0, 0, 1, 0, 0};
    vecs[1] = '{0, 1, 0, 1, 1};
    vecs[2] = '{0, 1, 0, 0, 1};
    for (int i = 3; i <= 10; i++) vecs[i] = '{0, 1, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0};

    // Reset is held with run and step high. Afterwards a step edge on an empty queue is dropped.
    reset = 1'b0; run = 1'b1; step = 1'b1;
    tick(); tick();
    check("rst_q_enable", q_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_data_hold", data_hold, 0);
    check("rst_valid", valid, 0);
    check("rst_pop_count", pop_count, 0);
    check("rst_q_push_pop", q_push_pop, 0);
    chk_en = 1'b1;
    reset = 1'b1; run = 1'b0;
    repeat (3) tick();
    check("empty_step_busy", busy, 0);
    p0 = pulses;
    fifo.push_back(4'h6);
    repeat (4) tick();
    check("held_step_no_pop", pulses - p0, 0);
    step = 1'b0; tick();
    fifo.delete(); tick();

    // Single-step mode, driven from the table.
    fifo.push_back(4'h5); fifo.push_back(4'h9); tick();
    p0 = pulses;
    for (int i = 0; i < 12; i++) begin
      run = vecs[i].run; step = vecs[i].step; clear = vecs[i].clear;
      tick();
      check($sformatf("vec%0d_q_enable", i), q_enable, vecs[i].en);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
    end
    check("step_one_pulse", pulses - p0, 1);
    check("step_data_hold", data_hold, 5);
    check("step_pop_count", pop_count, 1);
    check("step_valid", valid, 1);

    // Empty queue: a step edge is dropped, and a later push does not start a pop.
    fifo.delete(); tick();
    p0 = pulses;
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    fifo.push_back(4'h2);
    repeat (4) tick();
    check("empty_edge_no_pop", pulses - p0, 0);
    check("empty_edge_count", pop_count, 1);

    // Run mode with TICK_DIV=4. The queue holds 3, 7 and A.
    fifo.delete();
    clear = 1'b1; tick(); clear = 1'b0;
    fifo.push_back(4'h3); fifo.push_back(4'h7); fifo.push_back(4'hA); tick();
    run = 1'b1; c0 = cyc; prev_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (prev_en) caps.push_back(data_hold);
      if (q_enable) offs.push_back(cyc - c0);
      prev_en = q_enable;
    end
    check("run_pulse_count", offs.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("run_pulse%0d_cycle", i), (offs.size() > i) ? offs[i] : -1, 5 + 6 * i);
    end
    check("run_cap0", (caps.size() > 0) ? int'(caps[0]) : -1, 3);
    check("run_cap1", (caps.size() > 1) ? int'(caps[1]) : -1, 7);
    check("run_cap2", (caps.size() > 2) ? int'(caps[2]) : -1, 10);
    check("run_pop_count", pop_count, 3);
    check("run_retry_busy", busy, 1);
    run = 1'b0; tick(); tick();
    check("run_stop_busy", busy, 0);

    // Reset asserted in the POP cycle.
    fifo.push_back(4'hC); fifo.push_back(4'hD); tick();
    step = 1'b1; tick();
    check("rstpop_in_pop", q_enable, 1);
    reset = 1'b0; tick();
    check("rstpop_q_enable", q_enable, 0);
    check("rstpop_busy", busy, 0);
    check("rstpop_data_hold", data_hold, 0);
    check("rstpop_valid", valid, 0);
    check("rstpop_pop_count", pop_count, 0);
    reset = 1'b1; step = 1'b0; tick();

    // Clear asserted in the POP cycle. It beats the capture, but the queue still pops.
    step = 1'b1; tick(); step = 1'b0; tick(); tick();
    check("pre_clear_count", pop_count, 1);
    check("pre_clear_hold", data_hold, 13);
    fifo.push_back(4'hE); tick();
    step = 1'b1; tick();
    check("clrpop_in_pop", q_enable, 1);
    clear = 1'b1; sz = fifo.size();
    tick();
    check("clrpop_data_hold", data_hold, 0);
    check("clrpop_valid", valid, 0);
    check("clrpop_pop_count", pop_count, 0);
    check("clrpop_queue_popped", fifo.size(), sz - 1);
    clear = 1'b0; step = 1'b0; tick(); tick();

    // 256 pops from a refilled queue. pop_count wraps to 0 and valid stays high.
    fifo.delete(); clear = 1'b1; tick(); clear = 1'b0;
    run = 1'b1; n = 0; k = 0; guard = 0; chk255 = 1'b0;
    while (n < 256 && guard < 4000) begin
      if (fifo.size() < 4) begin
        k++;
        fifo.push_back(4'((k * 7 + 3) % 16));
      end
      tick(); guard++;
      if (chk255) begin
        check("wrap_count_255", pop_count, 255);
        chk255 = 1'b0;
      end
      if (q_enable) begin
        n++;
        if (n == 255) chk255 = 1'b1;
      end
    end
    check("wrap_reached_256", n, 256);
    run = 1'b0; tick();
    check("wrap_count_0", pop_count, 0);
    check("wrap_valid", valid, 1);
    check("wrap_data_hold", data_hold, 3);
    tick();

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      step  = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 63) == 0);
      reset = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) == 0 && fifo.size() < 8) fifo.push_back(4'($urandom_range(0, 15)));
      tick();
    end
    reset = 1'b1; run = 1'b0; step = 1'b0; clear = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
